// File: rtl/a2d_spi_serf_if.sv
// SPI link between the A2D monarch and the A2D serf emulator.
interface a2d_spi_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_serf.sv
// SPI serf standing in for an 8-channel 12-bit A2D. It answers each command with the
// sample of the channel named by the previous accepted command.
module a2d_spi_serf #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DW     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    a2d_spi_serf_if.slave        spi,
    input  logic [NUM_CH*DW-1:0] ch_data,
    output logic [15:0]          cmd_rcvd,
    output logic                 cmd_rdy,
    output logic [2:0]           chnl
);

    localparam int unsigned CMD_W = 16;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned PAD_W = CMD_W - DW;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         ss_sync, sclk_sync, mosi_sync;
    logic [CMD_W-1:0]   rx_shft, tx_shft, tx_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DW-1:0]      resp, sel_sample;
    logic               first_rise, fall_pend_q, fall_pend_d;
    logic               miso_q;
    logic               ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic               load_tx, shift_rx, shift_tx, accept;

    // Two meta flops plus one history flop per pin; SS_n syncs reset low so a frame
    // already under way at reset release never produces a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '0;
            sclk_sync <= '1;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[1:0],   spi.SS_n};
            sclk_sync <= {sclk_sync[1:0], spi.SCLK};
            mosi_sync <= {mosi_sync[1:0], spi.MOSI};
        end
    end

    assign ss_fall   = ~ss_sync[1]   &  ss_sync[2];
    assign ss_rise   =  ss_sync[1]   & ~ss_sync[2];
    assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fall_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fall_pend_q <= fall_pend_d;
        end
    end

    // Next state and datapath strobes; SS_rise outranks any SCLK edge in the same clk.
    always_comb begin
        state_d     = state_q;
        fall_pend_d = fall_pend_q;
        load_tx     = 1'b0;
        shift_rx    = 1'b0;
        shift_tx    = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_fall || fall_pend_q) begin
                    load_tx     = 1'b1;
                    fall_pend_d = 1'b0;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = DONE;
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                end else if (sclk_fall && first_rise) begin
                    shift_tx = 1'b1;
                end
            end
            DONE: begin
                accept      = (bit_cnt == CNT_W'(CMD_W));
                fall_pend_d = ss_fall;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rx_shft[13:11] == 3'(k)) sel_sample = ch_data[k*DW +: DW];
        end
    end

    // Transmit word is cleared at the end of every frame so MISO never replays stale bits.
    always_comb begin
        tx_d = tx_shft;
        if (load_tx)               tx_d = {{PAD_W{1'b0}}, resp};
        else if (shift_tx)         tx_d = {tx_shft[CMD_W-2:0], 1'b0};
        else if (state_q == DONE)  tx_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shft    <= '0;
            tx_shft    <= '0;
            bit_cnt    <= '0;
            first_rise <= 1'b0;
            resp       <= '0;
            cmd_rcvd   <= '0;
            chnl       <= '0;
            cmd_rdy    <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            tx_shft <= tx_d;
            miso_q  <= ~ss_sync[0] & tx_d[CMD_W-1];
            cmd_rdy <= accept;
            if (load_tx) begin
                bit_cnt    <= '0;
                first_rise <= 1'b0;
            end
            if (shift_rx) begin
                rx_shft    <= {rx_shft[CMD_W-2:0], mosi_sync[2]};
                first_rise <= 1'b1;
                if (bit_cnt != CNT_W'(CMD_W)) bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (accept) begin
                cmd_rcvd <= rx_shft;
                chnl     <= rx_shft[13:11];
                resp     <= sel_sample;
            end
        end
    end

    assign spi.MISO = miso_q;

endmodule

// File: tb/tb_a2d_spi_serf.sv
// Bench for a2d_spi_serf: directed frames from the plan followed by random frames,
// all checked against a one-transaction-lag response model.
module tb_a2d_spi_serf;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned DW     = 12;
    localparam int          HALF   = 60;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [DW-1:0]        ch [NUM_CH];
    logic [NUM_CH*DW-1:0] ch_data;
    logic [15:0]          cmd_rcvd;
    logic                 cmd_rdy;
    logic [2:0]           chnl;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_cnt  = 0;

    logic [DW-1:0] m_resp;
    logic [15:0]   m_cmd;
    logic [2:0]    m_chnl;

    a2d_spi_serf_if spi ();

    a2d_spi_serf #(.NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi      (spi.slave),
        .ch_data  (ch_data),
        .cmd_rcvd (cmd_rcvd),
        .cmd_rdy  (cmd_rdy),
        .chnl     (chnl)
    );

    always #5 clk = ~clk;

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < NUM_CH; k++) ch_data[k*DW +: DW] = ch[k];
    end

    always @(negedge clk) if (cmd_rdy === 1'b1) rdy_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One monarch transaction: the last nrise bits of 'bits' go out MSB first.
    // rst_at >= 0 pulses rst_n just before that SCLK rise.
    task automatic frame(input logic [31:0] bits, input int nrise, input int rst_at);
        logic [15:0] exp_w, got;
        int          nread, rdy0;
        exp_w = {4'h0, m_resp};
        got   = '0;
        nread = 0;
        rdy0  = rdy_cnt;
        spi.MOSI = bits[nrise-1];
        spi.SS_n = 1'b0;
        #HALF;
        spi.SCLK = 1'b0;
        #HALF;
        for (int i = 0; i < nrise; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #20;
                check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
                check("rst_cmd_rcvd", 32'(cmd_rcvd), 32'd0);
                check("rst_chnl", 32'(chnl), 32'd0);
                check("rst_miso", 32'(spi.MISO), 32'd0);
                m_resp = '0;
                m_cmd  = '0;
                m_chnl = '0;
                rst_n  = 1'b1;
                #HALF;
            end
            if (i < 16) begin
                got = {got[14:0], spi.MISO};
                nread++;
            end
            spi.SCLK = 1'b1;
            #HALF;
            if (i < nrise - 1) begin
                spi.SCLK = 1'b0;
                spi.MOSI = bits[nrise-2-i];
                #HALF;
            end
        end
        spi.SS_n = 1'b1;
        repeat (10) @(negedge clk);
        if (rst_at < 0) begin
            check("miso_rsp", 32'(got), 32'(exp_w >> (16 - nread)));
            if (nrise >= 16) begin
                m_cmd  = bits[15:0];
                m_chnl = bits[13:11];
                m_resp = ch[m_chnl];
            end
        end
        check("cmd_rdy_pulses", 32'(rdy_cnt - rdy0), (rst_at < 0 && nrise >= 16) ? 32'd1 : 32'd0);
        check("cmd_rcvd", 32'(cmd_rcvd), 32'(m_cmd));
        check("chnl", 32'(chnl), 32'(m_chnl));
        check("miso_idle", 32'(spi.MISO), 32'd0);
        #2;
    endtask

    initial begin
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        for (int k = 0; k < NUM_CH; k++) ch[k] = '0;
        m_resp = '0;
        m_cmd  = '0;
        m_chnl = '0;

        #22;
        check("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("reset_cmd_rcvd", 32'(cmd_rcvd), 32'd0);
        check("reset_chnl", 32'(chnl), 32'd0);
        check("reset_miso", 32'(spi.MISO), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #2;

        // Lagged response and snapshot isolation
        ch[4] = 12'hABC;
        ch[6] = 12'h5A5;
        frame(32'h2000, 16, -1);
        ch[4] = 12'h123;
        frame(32'h3000, 16, -1);

        // Aborted frame after 9 rises leaves everything untouched
        frame(32'h0800 >> 7, 9, -1);
        frame(32'h3000, 16, -1);

        // Reset in the middle of a frame, then a clean frame
        frame(32'h1800, 16, 7);
        frame(32'h2800, 16, -1);

        // A2D_intf-style channel pairs
        ch[0] = 12'h111;
        ch[4] = 12'h222;
        ch[5] = 12'h333;
        ch[6] = 12'h444;
        foreach (ch[k]) begin
            if (k == 0 || k == 4 || k == 5 || k == 6) begin
                frame(32'(k) << 11, 16, -1);
                frame(32'(k) << 11, 16, -1);
            end
        end

        // Random commands, random sample updates, short and over-long frames
        for (int r = 0; r < 24; r++) begin
            int kind, n;
            ch[$urandom_range(0, NUM_CH - 1)] = 12'($urandom);
            kind = $urandom_range(0, 5);
            n = (kind == 0) ? $urandom_range(1, 15) : (kind == 1) ? $urandom_range(17, 20) : 16;
            frame(32'($urandom), n, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
